// File: rtl/seg_scan_6.sv
// Six-digit multiplexed seven-segment scan driver with tear-free double buffering,
// inter-digit blanking and optional leading-zero suppression.
module seg_scan_6 #(
    parameter int SCAN_DIV  = 50_000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk50m,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [23:0] bcd,
    input  logic [5:0]  dp_in,
    input  logic        lz_blank,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  dig,
    output logic        pending,
    output logic        frame_start
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {BLANK, ON} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [29:0] staging_q, staging_d;
    logic [29:0] display_q, display_d;
    logic        pending_q, pending_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [5:0]  dig_q, dig_d;
    logic        fs_q, fs_d;

    logic        lit;
    logic [3:0]  curDigit;
    logic        curDp;
    logic        curSupp;
    logic [5:0]  supp;
    logic        allZero;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0:    decode = 7'h3F;
            4'h1:    decode = 7'h06;
            4'h2:    decode = 7'h5B;
            4'h3:    decode = 7'h4F;
            4'h4:    decode = 7'h66;
            4'h5:    decode = 7'h6D;
            4'h6:    decode = 7'h7D;
            4'h7:    decode = 7'h07;
            4'h8:    decode = 7'h7F;
            4'h9:    decode = 7'h6F;
            4'hA:    decode = 7'h40;
            default: decode = 7'h00;
        endcase
    endfunction

    // Slot sequencing, staging and frame transfer; outputs are derived from the
    // next display value so a transfer is visible on the very edge it happens.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        staging_d = staging_q;
        display_d = display_q;
        pending_d = pending_q;
        lit       = 1'b0;
        fs_d      = 1'b0;

        if (load) begin
            staging_d = {dp_in, bcd};
            pending_d = 1'b1;
        end

        if (en) begin
            case (state_q)
                BLANK: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(BLANK_CYC - 1)) begin
                        state_d = ON;
                        lit     = 1'b1;
                        if (idx_q == 3'd0) begin
                            fs_d = 1'b1;
                            if (load) begin
                                display_d = {dp_in, bcd};
                                pending_d = 1'b0;
                            end else if (pending_q) begin
                                display_d = staging_q;
                                pending_d = 1'b0;
                            end
                        end
                    end
                end
                ON: begin
                    if (cnt_q == CW'(SCAN_DIV - 1)) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        idx_d   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        lit   = 1'b1;
                    end
                end
                default: state_d = BLANK;
            endcase
        end
    end

    // Digit k is suppressed when it and every more significant digit are zero.
    always_comb begin
        supp    = '0;
        allZero = 1'b1;
        for (int k = 5; k >= 1; k--) begin
            allZero = allZero & (display_d[4*k +: 4] == 4'd0);
            supp[k] = allZero;
        end
    end

    always_comb begin
        curDigit = 4'd0;
        curDp    = 1'b0;
        curSupp  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (idx_q == 3'(k)) begin
                curDigit = display_d[4*k +: 4];
                curDp    = display_d[24 + k];
                curSupp  = supp[k];
            end
        end
    end

    always_comb begin
        seg_d = 7'h00;
        dp_d  = 1'b0;
        dig_d = 6'h3F;
        if (lit) begin
            seg_d = (lz_blank && curSupp) ? 7'h00 : decode(curDigit);
            dp_d  = curDp;
            dig_d = ~(6'b1 << idx_q);
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BLANK;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            staging_q <= '0;
            display_q <= '0;
            pending_q <= 1'b0;
            seg_q     <= 7'h00;
            dp_q      <= 1'b0;
            dig_q     <= 6'h3F;
            fs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            staging_q <= staging_d;
            display_q <= display_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            dig_q     <= dig_d;
            fs_q      <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign dig         = dig_q;
    assign pending     = pending_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_6.sv
// Directed bench for seg_scan_6 with SCAN_DIV=10, BLANK_CYC=2 (60-cycle frame).
module tb_seg_scan_6;

    logic        clk50m = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [23:0] bcd;
    logic [5:0]  dp_in;
    logic        lz_blank;
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  dig;
    logic        pending;
    logic        frame_start;

    int total = 0;
    int bad   = 0;
    int ph    = 0;

    seg_scan_6 #(.SCAN_DIV(10), .BLANK_CYC(2)) dut (
        .clk50m      (clk50m),
        .rst_n       (rst_n),
        .en          (en),
        .load        (load),
        .bcd         (bcd),
        .dp_in       (dp_in),
        .lz_blank    (lz_blank),
        .seg         (seg),
        .dp          (dp),
        .dig         (dig),
        .pending     (pending),
        .frame_start (frame_start)
    );

    always #5 clk50m = ~clk50m;

    // ph is the position within the 60-cycle frame after the most recent edge.
    task automatic tick();
        @(posedge clk50m);
        #1;
        if (en && rst_n) ph = (ph + 1) % 60;
    endtask

    task automatic waitPhase(input int p);
        int n = 0;
        while (ph != p && n < 200) begin
            tick();
            n++;
        end
        if (ph != p) begin
            bad++;
            $display("[TB] FAIL waitPhase: got phase %0d want %0d", ph, p);
        end
        total++;
    endtask

    function automatic logic [5:0] expDig(input int p);
        if (p % 10 >= 2) return ~(6'b1 << (p / 10));
        return 6'h3F;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; load = 1'b0; bcd = '0; dp_in = '0; lz_blank = 1'b0;
        #12;
        total++; if (dig !== 6'h3F) begin bad++; $display("[TB] FAIL reset_dig: got %h want 3f", dig); end
        total++; if (seg !== 7'h00) begin bad++; $display("[TB] FAIL reset_seg: got %h want 00", seg); end
        total++; if (dp !== 1'b0) begin bad++; $display("[TB] FAIL reset_dp: got %b want 0", dp); end
        total++; if (pending !== 1'b0) begin bad++; $display("[TB] FAIL reset_pending: got %b want 0", pending); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_fs: got %b want 0", frame_start); end
        @(negedge clk50m);
        rst_n = 1'b1;
        en    = 1'b1;
        ph    = 0;
    endtask

    task automatic test_first_frame();
        for (int e = 0; e < 60; e++) begin
            tick();
            total++; if (dig !== expDig(ph)) begin bad++; $display("[TB] FAIL frame_dig ph=%0d: got %h want %h", ph, dig, expDig(ph)); end
            total++; if (seg !== ((ph % 10 >= 2) ? 7'h3F : 7'h00)) begin bad++; $display("[TB] FAIL frame_seg ph=%0d: got %h", ph, seg); end
            total++; if (frame_start !== (ph == 2)) begin bad++; $display("[TB] FAIL frame_fs ph=%0d: got %b", ph, frame_start); end
        end
    endtask

    task automatic test_tear_free();
        waitPhase(25);
        load = 1'b1; bcd = 24'h123456; dp_in = 6'b0;
        tick();
        load = 1'b0;
        total++; if (pending !== 1'b1) begin bad++; $display("[TB] FAIL tear_pending: got %b want 1", pending); end
        total++; if (seg !== 7'h3F) begin bad++; $display("[TB] FAIL tear_old_d2: got %h want 3f", seg); end
        total++; if (dig !== 6'h3B) begin bad++; $display("[TB] FAIL tear_dig2: got %h want 3b", dig); end
        waitPhase(59);
        total++; if (seg !== 7'h3F) begin bad++; $display("[TB] FAIL tear_old_d5: got %h want 3f", seg); end
        waitPhase(1);
        total++; if (pending !== 1'b1) begin bad++; $display("[TB] FAIL tear_pending_blank: got %b want 1", pending); end
        tick();
        total++; if (seg !== 7'h7D) begin bad++; $display("[TB] FAIL tear_new_d0: got %h want 7d", seg); end
        total++; if (pending !== 1'b0) begin bad++; $display("[TB] FAIL tear_pending_clr: got %b want 0", pending); end
        total++; if (frame_start !== 1'b1) begin bad++; $display("[TB] FAIL tear_fs: got %b want 1", frame_start); end
        waitPhase(52);
        total++; if (seg !== 7'h06) begin bad++; $display("[TB] FAIL tear_new_d5: got %h want 06", seg); end
        total++; if (dig !== 6'h1F) begin bad++; $display("[TB] FAIL tear_dig5: got %h want 1f", dig); end
    endtask

    task automatic test_load_on_transfer();
        waitPhase(1);
        load = 1'b1; bcd = 24'h000009;
        tick();
        load = 1'b0;
        total++; if (seg !== 7'h6F) begin bad++; $display("[TB] FAIL bypass_seg: got %h want 6f", seg); end
        total++; if (pending !== 1'b0) begin bad++; $display("[TB] FAIL bypass_pending: got %b want 0", pending); end
        total++; if (dig !== 6'h3E) begin bad++; $display("[TB] FAIL bypass_dig: got %h want 3e", dig); end
        waitPhase(12);
        total++; if (seg !== 7'h3F) begin bad++; $display("[TB] FAIL bypass_d1: got %h want 3f", seg); end
    endtask

    task automatic test_leading_zero();
        lz_blank = 1'b1;
        waitPhase(5);
        load = 1'b1; bcd = 24'h000120;
        tick();
        load = 1'b0;
        waitPhase(2);
        total++; if (seg !== 7'h3F) begin bad++; $display("[TB] FAIL lz_d0: got %h want 3f", seg); end
        waitPhase(12);
        total++; if (seg !== 7'h5B) begin bad++; $display("[TB] FAIL lz_d1: got %h want 5b", seg); end
        waitPhase(22);
        total++; if (seg !== 7'h06) begin bad++; $display("[TB] FAIL lz_d2: got %h want 06", seg); end
        waitPhase(32);
        total++; if (seg !== 7'h00) begin bad++; $display("[TB] FAIL lz_d3: got %h want 00", seg); end
        total++; if (dig !== 6'h37) begin bad++; $display("[TB] FAIL lz_dig3: got %h want 37", dig); end
        waitPhase(42);
        total++; if (seg !== 7'h00) begin bad++; $display("[TB] FAIL lz_d4: got %h want 00", seg); end
        waitPhase(52);
        total++; if (seg !== 7'h00) begin bad++; $display("[TB] FAIL lz_d5: got %h want 00", seg); end
        waitPhase(55);
        load = 1'b1; bcd = 24'h000000;
        tick();
        load = 1'b0;
        waitPhase(2);
        total++; if (seg !== 7'h3F) begin bad++; $display("[TB] FAIL lz_zero_d0: got %h want 3f", seg); end
        waitPhase(12);
        total++; if (seg !== 7'h00) begin bad++; $display("[TB] FAIL lz_zero_d1: got %h want 00", seg); end
    endtask

    task automatic test_special_codes();
        lz_blank = 1'b0;
        waitPhase(15);
        load = 1'b1; bcd = 24'hA0000F; dp_in = 6'b000001;
        tick();
        load = 1'b0; dp_in = 6'b0;
        waitPhase(2);
        total++; if (seg !== 7'h00) begin bad++; $display("[TB] FAIL spec_d0_seg: got %h want 00", seg); end
        total++; if (dp !== 1'b1) begin bad++; $display("[TB] FAIL spec_d0_dp: got %b want 1", dp); end
        total++; if (dig !== 6'h3E) begin bad++; $display("[TB] FAIL spec_d0_dig: got %h want 3e", dig); end
        waitPhase(52);
        total++; if (seg !== 7'h40) begin bad++; $display("[TB] FAIL spec_d5_seg: got %h want 40", seg); end
        total++; if (dp !== 1'b0) begin bad++; $display("[TB] FAIL spec_d5_dp: got %b want 0", dp); end
    endtask

    task automatic test_enable_and_reset();
        waitPhase(35);
        en = 1'b0;
        tick();
        total++; if (dig !== 6'h3F) begin bad++; $display("[TB] FAIL en_dig: got %h want 3f", dig); end
        total++; if (seg !== 7'h00) begin bad++; $display("[TB] FAIL en_seg: got %h want 00", seg); end
        for (int i = 0; i < 19; i++) begin
            tick();
            total++; if (dig !== 6'h3F) begin bad++; $display("[TB] FAIL en_hold_dig %0d: got %h want 3f", i, dig); end
        end
        total++; if (frame_start !== 1'b0) begin bad++; $display("[TB] FAIL en_fs: got %b want 0", frame_start); end
        en = 1'b1;
        tick();
        total++; if (dig !== 6'h37) begin bad++; $display("[TB] FAIL en_resume_dig: got %h want 37", dig); end
        total++; if (seg !== 7'h3F) begin bad++; $display("[TB] FAIL en_resume_seg: got %h want 3f", seg); end
        waitPhase(39);
        total++; if (dig !== 6'h37) begin bad++; $display("[TB] FAIL en_last_on: got %h want 37", dig); end
        tick();
        total++; if (dig !== 6'h3F) begin bad++; $display("[TB] FAIL en_blank_after: got %h want 3f", dig); end
        waitPhase(45);
        load = 1'b1; bcd = 24'h777777;
        tick();
        load = 1'b0;
        total++; if (pending !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre_pending: got %b want 1", pending); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (dig !== 6'h3F) begin bad++; $display("[TB] FAIL rst_async_dig: got %h want 3f", dig); end
        total++; if (pending !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_pending: got %b want 0", pending); end
        total++; if (seg !== 7'h00) begin bad++; $display("[TB] FAIL rst_async_seg: got %h want 00", seg); end
        @(negedge clk50m);
        rst_n = 1'b1;
        ph    = 0;
        waitPhase(2);
        total++; if (seg !== 7'h3F) begin bad++; $display("[TB] FAIL rst_discard_seg: got %h want 3f", seg); end
        total++; if (frame_start !== 1'b1) begin bad++; $display("[TB] FAIL rst_first_fs: got %b want 1", frame_start); end
        total++; if (pending !== 1'b0) begin bad++; $display("[TB] FAIL rst_first_pending: got %b want 0", pending); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_tear_free();
        test_load_on_transfer();
        test_leading_zero();
        test_special_codes();
        test_enable_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
